// File: rtl/dig_stopwatch_core.sv
// dig_stopwatch_core: BCD MM:SS.CC stopwatch datapath with lap capture,
// driven by single-cycle command pulses from the AXI register file.
module dig_stopwatch_core #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 100
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        start_pulse,
  input  logic        stop_pulse,
  input  logic        clear_pulse,
  input  logic        lap_pulse,
  output logic [23:0] time_bcd,
  output logic [23:0] lap_bcd,
  output logic        lap_valid,
  output logic        running,
  output logic        overflow,
  output logic        tick
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
  state_t        state, state_n;
  logic [PW-1:0] pre;
  logic [23:0]   time_inc;
  logic          carry, tick_n;
  logic [3:0]    dig, lim;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) state <= IDLE;
    else state <= state_n;
  // clear beats stop beats start; a stop outside RUNNING still masks start
  always_comb begin
    state_n = clear_pulse ? IDLE :
              stop_pulse  ? (state == RUNNING ? PAUSED : state) :
              start_pulse ? RUNNING : state;
  end
  assign running = state == RUNNING;
  assign tick_n  = running && pre == PW'(DIV - 1);
  // digits from cs_u upward; tens of seconds and tens of minutes roll at 5
  always_comb begin
    time_inc = time_bcd;
    carry    = 1'b1;
    dig      = '0;
    lim      = '0;
    for (int i = 0; i < 6; i++) begin
      dig = time_bcd[4*i +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      time_inc[4*i +: 4] = carry ? (dig == lim ? 4'd0 : dig + 4'd1) : dig;
      carry = carry && dig == lim;
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      pre       <= '0;
      time_bcd  <= '0;
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
      overflow  <= 1'b0;
      tick      <= 1'b0;
    end else if (clear_pulse) begin
      pre       <= '0;
      time_bcd  <= '0;
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
      overflow  <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= tick_n;
      if (running) pre <= tick_n ? '0 : pre + 1'b1;
      else if (state == IDLE) pre <= '0;
      if (tick_n) time_bcd <= time_inc;
      if (tick_n && carry) overflow <= 1'b1;
      if (lap_pulse && state != IDLE) begin
        lap_bcd   <= time_bcd;
        lap_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dig_stopwatch_core.sv
// tb_dig_stopwatch_core: randomized and directed checks of the stopwatch core
// against an elapsed-running-cycles reference model (DIV = 4).
module tb_dig_stopwatch_core;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_pulse = 1'b0, stop_pulse = 1'b0, clear_pulse = 1'b0, lap_pulse = 1'b0;
  logic [23:0] time_bcd, lap_bcd;
  logic        lap_valid, running, overflow, tick;
  logic [51:0] obs;
  int          checks = 0, errors = 0;
  int          m_cyc, m_lap;
  bit          m_run, m_idle, m_lapv, m_tick;

  always #5 clk = ~clk;

  dig_stopwatch_core #(.CLK_FREQ_HZ(400), .TICK_HZ(100)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .clear_pulse(clear_pulse), .lap_pulse(lap_pulse),
    .time_bcd(time_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
    .running(running), .overflow(overflow), .tick(tick)
  );

  assign obs = {time_bcd, lap_bcd, lap_valid, running, overflow, tick};

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // elapsed time is simply the number of running cycles divided by DIV
  function automatic logic [51:0] exp_vec();
    return {to_bcd((m_cyc / 4) % 360000), to_bcd(m_lap), m_lapv, m_run,
            (m_cyc / 4) >= 360000, m_tick};
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_lap = 0; m_run = 0; m_idle = 1; m_lapv = 0; m_tick = 0;
  endfunction

  task automatic cyc(input bit st, input bit sp, input bit cl, input bit lp);
    start_pulse = st; stop_pulse = sp; clear_pulse = cl; lap_pulse = lp;
    @(posedge clk);
    if (cl) model_reset();
    else begin
      m_tick = 0;
      if (lp && !m_idle) begin
        m_lap  = (m_cyc / 4) % 360000;
        m_lapv = 1;
      end
      if (m_run) begin
        m_cyc++;
        m_tick = (m_cyc % 4) == 0;
      end
      if (sp) m_run = 0;
      else if (st) begin
        m_run  = 1;
        m_idle = 0;
      end
    end
    #1;
    start_pulse = 0; stop_pulse = 0; clear_pulse = 0; lap_pulse = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start_pulse = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 52'd0) begin errors++; $display("FAIL reset_hold got %h want 0", obs); end
    rst_n = 1; start_pulse = 0;
    cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL reset_start_running got %b want 1", running); end
    repeat (3) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, tick} !== 25'h0) begin errors++; $display("FAIL reset_pre_tick got %h/%b want 000000/0", time_bcd, tick); end
    cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, tick} !== {24'h000001, 1'b1}) begin errors++; $display("FAIL reset_first_tick got %h/%b want 000001/1", time_bcd, tick); end
  endtask

  task automatic test_count();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 400; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (tick !== (i % 4 == 0)) begin errors++; $display("FAIL tick_cadence cycle %0d got %b want %b", i, tick, i % 4 == 0); end
    end
    checks++;
    if (time_bcd !== 24'h000100) begin errors++; $display("FAIL count_100 got %h want 000100", time_bcd); end
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (24000) cyc(0, 0, 0, 0);
    checks++;
    if (time_bcd !== 24'h010000) begin errors++; $display("FAIL count_6000 got %h want 010000", time_bcd); end
  endtask

  task automatic test_pause();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, tick} !== {24'h000001, 1'b1}) begin errors++; $display("FAIL pause_tick got %h/%b want 000001/1", time_bcd, tick); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, running} !== {24'h000001, 1'b0}) begin errors++; $display("FAIL pause_hold got %h/%b want 000001/0", time_bcd, running); end
    cyc(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", running); end
    cyc(0, 0, 0, 0);
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL resume_early_tick got %b want 0", tick); end
    cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, tick} !== {24'h000002, 1'b1}) begin errors++; $display("FAIL resume_tick got %h/%b want 000002/1", time_bcd, tick); end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (4 * 359999) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, overflow} !== {24'h595999, 1'b0}) begin errors++; $display("FAIL wrap_max got %h/%b want 595999/0", time_bcd, overflow); end
    repeat (4) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, overflow} !== {24'h000000, 1'b1}) begin errors++; $display("FAIL wrap_zero got %h/%b want 000000/1", time_bcd, overflow); end
    repeat (4) cyc(0, 0, 0, 0);
    checks++;
    if ({time_bcd, overflow} !== {24'h000001, 1'b1}) begin errors++; $display("FAIL wrap_continue got %h/%b want 000001/1", time_bcd, overflow); end
  endtask

  task automatic test_lap();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (39) cyc(0, 0, 0, 0);
    checks++;
    if (time_bcd !== 24'h000009) begin errors++; $display("FAIL lap_setup got %h want 000009", time_bcd); end
    cyc(0, 0, 0, 1);
    checks++;
    if ({lap_bcd, lap_valid, time_bcd} !== {24'h000009, 1'b1, 24'h000010}) begin
      errors++; $display("FAIL lap_on_tick got lap %h valid %b time %h want 000009/1/000010", lap_bcd, lap_valid, time_bcd);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if (lap_valid !== 1'b0) begin errors++; $display("FAIL lap_idle got %b want 0", lap_valid); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    checks++;
    if (obs !== 52'd0) begin errors++; $display("FAIL clear_lap_start got %h want 0", obs); end
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_start_running got %b want 0", running); end
    repeat (5) cyc(0, 0, 0, 0);
    checks++;
    if (time_bcd !== 24'h000001) begin errors++; $display("FAIL stop_start_hold got %h want 000001", time_bcd); end
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop_start_paused got %b want 0", running); end
    cyc(1, 0, 0, 0);
    checks++;
    if ({running, time_bcd} !== {1'b1, 24'h000001}) begin errors++; $display("FAIL resume_after_pause got %b/%h want 1/000001", running, time_bcd); end
  endtask

  task automatic test_random();
    bit st, sp, cl, lp;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      st = $urandom_range(0, 7) == 0;
      sp = $urandom_range(0, 11) == 0;
      cl = $urandom_range(0, 63) == 0;
      lp = $urandom_range(0, 9) == 0;
      cyc(st, sp, cl, lp);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, obs, exp_vec()); end
    end
    cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== 52'd0) begin errors++; $display("FAIL reset_midcount got %h want 0", obs); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_lap();
    test_simultaneous();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
